// File: rtl/sram_ctrl.sv
// Bridges the SoC RAM window to a 16-bit asynchronous SRAM: each 32-bit access
// becomes one or two halfword beats of programmable length, with a one-deep pending slot.
package sram_ctrl_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW          = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  mem_in_type        ram_in,
    output mem_out_type       ram_out,
    output logic [AW-1:0]     sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic              ovf
);

    typedef enum logic [2:0] {IDLE, BEAT0, GAP, BEAT1, DONE} state_t;

    typedef struct packed {
        logic [AW-2:0] word;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
        logic          err;
    } req_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    function automatic req_t decode(input mem_in_type r);
        req_t q;
        q.word  = r.mem_addr[AW:2];
        q.wdata = r.mem_wdata;
        q.wstrb = r.mem_wstrb;
        q.err   = |r.mem_addr[31:AW+2];
        return q;
    endfunction

    // Out-of-range requests go straight to the response; writes with an idle low half skip BEAT0.
    function automatic state_t first_state(input req_t r);
        if (r.err)
            return DONE;
        else if (r.wstrb == 4'b0 || r.wstrb[1:0] != 2'b0)
            return BEAT0;
        else
            return BEAT1;
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    req_t          req_q, req_d;
    req_t          pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [15:0]   lo_q, lo_d, hi_q, hi_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   dq_o_q, dq_o_d;
    logic          dq_oe_q, dq_oe_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          lb_n_q, lb_n_d;
    logic          ub_n_q, ub_n_d;

    req_t in_req;
    logic cur_read;
    logic beat_hi;
    logic unused_bits;

    assign in_req      = decode(ram_in);
    assign cur_read    = (req_q.wstrb == 4'b0);
    assign unused_bits = ^{ram_in.mem_instr, ram_in.mem_addr[1:0], ram_in.mem_addr[AW+1]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        ovf_d        = ovf_q;

        case (state_q)
            IDLE: begin
                if (ram_in.mem_valid) begin
                    req_d   = in_req;
                    state_d = first_state(in_req);
                    cnt_d   = '0;
                end
            end
            BEAT0: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (cur_read)
                        lo_d = sram_dq_i;
                    if (!cur_read && req_q.wstrb[3:2] == 2'b0)
                        state_d = DONE;
                    else if (!cur_read && WAIT_CYCLES == 0)
                        state_d = GAP;
                    else
                        state_d = BEAT1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GAP: begin
                state_d = BEAT1;
            end
            BEAT1: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (cur_read)
                        hi_d = sram_dq_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                cnt_d = '0;
                // The slot is freed this cycle, so a simultaneous new valid refills it.
                if (pend_valid_q) begin
                    req_d        = pend_q;
                    state_d      = first_state(pend_q);
                    pend_valid_d = ram_in.mem_valid;
                    pend_d       = in_req;
                end else if (ram_in.mem_valid) begin
                    req_d   = in_req;
                    state_d = first_state(in_req);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ram_in.mem_valid && state_q != IDLE && state_q != DONE) begin
            if (pend_valid_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_d       = in_req;
            end
        end

        // Pins are registered from the next state so every beat starts cleanly on a clock edge.
        beat_hi = (state_d == BEAT1);
        addr_d  = addr_q;
        dq_o_d  = dq_o_q;
        dq_oe_d = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        if (state_d == BEAT0 || state_d == BEAT1) begin
            ce_n_d = 1'b0;
            addr_d = {req_d.word, beat_hi};
            if (req_d.wstrb == 4'b0) begin
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end else begin
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                lb_n_d  = ~(beat_hi ? req_d.wstrb[2] : req_d.wstrb[0]);
                ub_n_d  = ~(beat_hi ? req_d.wstrb[3] : req_d.wstrb[1]);
                dq_o_d  = beat_hi ? req_d.wdata[31:16] : req_d.wdata[15:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
            ovf_q        <= 1'b0;
            addr_q       <= '0;
            dq_o_q       <= '0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            ovf_q        <= ovf_d;
            addr_q       <= addr_d;
            dq_o_q       <= dq_o_d;
            dq_oe_q      <= dq_oe_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            lb_n_q       <= lb_n_d;
            ub_n_q       <= ub_n_d;
        end
    end

    always_comb begin
        ram_out = '0;
        if (state_q == DONE) begin
            ram_out.mem_ready = 1'b1;
            ram_out.mem_error = req_q.err;
            if (!req_q.err && cur_read)
                ram_out.mem_rdata = {hi_q, lo_q};
        end
    end

    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_ub_n  = ub_n_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: four controllers with WAIT_CYCLES 0..3 over behavioural SRAMs,
// plus a small-window instance for the address range check.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int NW  = 4;
    localparam int AWS = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_in_type     rin      [NW];
    mem_out_type    rout     [NW];
    logic [AWS-1:0] saddr    [NW];
    logic [15:0]    dq_o_a   [NW];
    logic [15:0]    dq_i_a   [NW];
    logic           dq_oe_a  [NW];
    logic           ce_n_a   [NW];
    logic           oe_n_a   [NW];
    logic           we_n_a   [NW];
    logic           lb_n_a   [NW];
    logic           ub_n_a   [NW];
    logic           ovf_a    [NW];

    for (genvar g = 0; g < NW; g++) begin : g_dut
        sram_ctrl #(.AW(AWS), .WAIT_CYCLES(g)) u_dut (
            .clock(clock), .reset(reset), .ram_in(rin[g]), .ram_out(rout[g]),
            .sram_addr(saddr[g]), .sram_dq_o(dq_o_a[g]), .sram_dq_i(dq_i_a[g]),
            .sram_dq_oe(dq_oe_a[g]), .sram_ce_n(ce_n_a[g]), .sram_oe_n(oe_n_a[g]),
            .sram_we_n(we_n_a[g]), .sram_lb_n(lb_n_a[g]), .sram_ub_n(ub_n_a[g]),
            .ovf(ovf_a[g])
        );
    end

    mem_in_type  rin_r;
    mem_out_type rout_r;
    logic [3:0]  saddr_r;
    logic [15:0] dq_o_r;
    logic [15:0] dq_i_r;
    logic        dq_oe_r, ce_n_r, oe_n_r, we_n_r, lb_n_r, ub_n_r, ovf_r;
    assign dq_i_r = 16'h0;

    sram_ctrl #(.AW(4), .WAIT_CYCLES(0)) u_range (
        .clock(clock), .reset(reset), .ram_in(rin_r), .ram_out(rout_r),
        .sram_addr(saddr_r), .sram_dq_o(dq_o_r), .sram_dq_i(dq_i_r),
        .sram_dq_oe(dq_oe_r), .sram_ce_n(ce_n_r), .sram_oe_n(oe_n_r),
        .sram_we_n(we_n_r), .sram_lb_n(lb_n_r), .sram_ub_n(ub_n_r), .ovf(ovf_r)
    );

    // Reference memory holds 32-bit words; the SRAM model holds halfwords and is loaded from it.
    logic [31:0] ref_mem [NW][128];
    logic [15:0] smem    [NW][256];
    logic        init_go;

    always @(posedge clock) begin
        if (init_go) begin
            for (int k = 0; k < NW; k++)
                for (int i = 0; i < 128; i++) begin
                    smem[k][2*i]   <= ref_mem[k][i][15:0];
                    smem[k][2*i+1] <= ref_mem[k][i][31:16];
                end
        end else begin
            for (int k = 0; k < NW; k++)
                if (!ce_n_a[k] && !we_n_a[k]) begin
                    if (!lb_n_a[k]) smem[k][saddr[k]][7:0]  <= dq_o_a[k][7:0];
                    if (!ub_n_a[k]) smem[k][saddr[k]][15:8] <= dq_o_a[k][15:8];
                end
        end
    end

    always_comb begin
        for (int k = 0; k < NW; k++)
            dq_i_a[k] = (!ce_n_a[k] && !oe_n_a[k]) ? smem[k][saddr[k]] : 16'hDEAD;
    end

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Issues one request and waits (bounded) for its ready pulse; lat = -1 means no response.
    task automatic apply_stimulus(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] strb, output int lat,
                                  output logic [31:0] rdata, output logic err);
        rin[sel] = '{1'b1, 1'b0, addr, wdata, strb};
        lat   = -1;
        rdata = '0;
        err   = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clock); #1;
            rin[sel].mem_valid = 1'b0;
            if (rout[sel].mem_ready) begin
                lat   = k;
                rdata = rout[sel].mem_rdata;
                err   = rout[sel].mem_error;
                break;
            end
        end
        @(posedge clock); #1;
        check_output("ready_pulse_width", {31'b0, rout[sel].mem_ready}, 32'b0);
    endtask

    function automatic int exp_latency(input int w, input logic [3:0] s, input logic e);
        int beats;
        if (e) return 1;
        if (s == 4'b0) return 2 * (w + 1) + 1;
        beats = ((s[1:0] != 0) ? 1 : 0) + ((s[3:2] != 0) ? 1 : 0);
        if (beats == 1) return w + 2;
        return 2 * (w + 1) + 1 + ((w == 0) ? 1 : 0);
    endfunction

    int          lat_got;
    logic [31:0] rd_got;
    logic        err_got;
    int          n_ready, first_rdy, second_rdy;
    logic [31:0] first_data;
    logic        ce6;
    int unsigned word;
    logic [31:0] a, d, exp_rd;
    logic [3:0]  st;
    logic        e;
    int unsigned r;

    initial begin
        for (int k = 0; k < NW; k++) rin[k] = '0;
        rin_r   = '0;
        init_go = 1'b0;

        vecs.push_back('{1, 32'h20,  32'h0,        4'h0, 32'hABCD1234, 1'b0, 5});
        vecs.push_back('{0, 32'h40,  32'h00EE0000, 4'h4, 32'h0,        1'b0, 2});
        vecs.push_back('{0, 32'h40,  32'h0,        4'h0, 32'h00EE0000, 1'b0, 3});
        vecs.push_back('{0, 32'h44,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 4});
        vecs.push_back('{0, 32'h44,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 3});
        vecs.push_back('{2, 32'h80,  32'h89ABCDEF, 4'hF, 32'h0,        1'b0, 7});
        vecs.push_back('{2, 32'h80,  32'h0,        4'h0, 32'h89ABCDEF, 1'b0, 7});
        vecs.push_back('{3, 32'h84,  32'h5555AAAA, 4'h3, 32'h0,        1'b0, 5});
        vecs.push_back('{3, 32'h84,  32'h0,        4'h0, 32'h0000AAAA, 1'b0, 9});
        vecs.push_back('{1, 32'h48,  32'h11223344, 4'h1, 32'h0,        1'b0, 3});
        vecs.push_back('{1, 32'h48,  32'h0,        4'h0, 32'h00000044, 1'b0, 5});
        vecs.push_back('{1, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1, 1});
        vecs.push_back('{3, 32'h88,  32'hDEAD0000, 4'hC, 32'h0,        1'b0, 5});
        vecs.push_back('{3, 32'h88,  32'h0,        4'h0, 32'hDEAD0000, 1'b0, 9});
        vecs.push_back('{2, 32'h8C,  32'h12345678, 4'h6, 32'h0,        1'b0, 7});
        vecs.push_back('{2, 32'h8C,  32'h0,        4'h0, 32'h00345600, 1'b0, 7});

        for (int k = 0; k < NW; k++)
            for (int i = 0; i < 128; i++) ref_mem[k][i] = '0;
        ref_mem[1][8] = 32'hABCD1234;
        init_go = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        init_go = 1'b0;

        check_output("reset_ram_out", 32'(rout[0]), 32'h0);
        check_output("reset_strobes", {27'b0, ce_n_a[0], oe_n_a[0], we_n_a[0], lb_n_a[0], ub_n_a[0]}, 32'h1F);
        check_output("reset_dq_oe", {31'b0, dq_oe_a[0]}, 32'h0);
        check_output("reset_addr", {24'b0, saddr[0]}, 32'h0);
        check_output("reset_dq_o", {16'b0, dq_o_a[0]}, 32'h0);
        check_output("reset_ovf", {31'b0, ovf_a[0]}, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].sel, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat_got, rd_got, err_got);
            check_output($sformatf("vec%0d_rdata", i), rd_got, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d_error", i), {31'b0, err_got}, {31'b0, vecs[i].exp_err});
            check_output($sformatf("vec%0d_latency", i), 32'(lat_got), 32'(vecs[i].exp_lat));
        end

        // Single-lane write seen on the pins.
        rin[0] = '{1'b1, 1'b0, 32'h40, 32'h00EE0000, 4'h4};
        @(posedge clock); #1;
        rin[0].mem_valid = 1'b0;
        check_output("bytewr_addr", {24'b0, saddr[0]}, 32'h21);
        check_output("bytewr_pins", {26'b0, ce_n_a[0], oe_n_a[0], we_n_a[0], lb_n_a[0], ub_n_a[0], dq_oe_a[0]}, 32'b010011);
        check_output("bytewr_dq_o", {16'b0, dq_o_a[0]}, 32'h00EE);
        @(posedge clock); #1;
        check_output("bytewr_ready", {31'b0, rout[0].mem_ready}, 32'h1);
        check_output("bytewr_idle_pins", {29'b0, ce_n_a[0], we_n_a[0], dq_oe_a[0]}, 32'b110);
        @(posedge clock); #1;

        // Out-of-range request on the small window.
        rin_r = '{1'b1, 1'b0, 32'h40, 32'h0, 4'h0};
        @(posedge clock); #1;
        rin_r.mem_valid = 1'b0;
        check_output("range_ready", {31'b0, rout_r.mem_ready}, 32'h1);
        check_output("range_error", {31'b0, rout_r.mem_error}, 32'h1);
        check_output("range_rdata", rout_r.mem_rdata, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            check_output("range_ce_n", {31'b0, ce_n_r}, 32'h1);
            @(posedge clock); #1;
        end

        // Back-to-back with a pending request and an overflowing third valid.
        check_output("b2b_ovf_before", {31'b0, ovf_a[1]}, 32'h0);
        rin[1] = '{1'b1, 1'b0, 32'h20, 32'h0, 4'h0};
        n_ready = 0; first_rdy = -1; second_rdy = -1; ce6 = 1'b1; first_data = '0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clock); #1;
            if (k == 1)
                rin[1] = '{1'b1, 1'b0, 32'h50, 32'h0BADBEEF, 4'hF};
            else if (k == 2)
                rin[1] = '{1'b1, 1'b0, 32'h60, 32'h0, 4'h0};
            else
                rin[1].mem_valid = 1'b0;
            if (rout[1].mem_ready) begin
                n_ready++;
                if (n_ready == 1) begin
                    first_rdy  = k;
                    first_data = rout[1].mem_rdata;
                end else begin
                    second_rdy = k;
                end
            end
            if (k == 6) ce6 = ce_n_a[1];
        end
        check_output("b2b_first_ready", 32'(first_rdy), 32'd5);
        check_output("b2b_first_rdata", first_data, 32'hABCD1234);
        check_output("b2b_no_bubble_ce_n", {31'b0, ce6}, 32'h0);
        check_output("b2b_second_ready", 32'(second_rdy), 32'd10);
        check_output("b2b_ready_count", 32'(n_ready), 32'd2);
        check_output("b2b_ovf", {31'b0, ovf_a[1]}, 32'h1);
        apply_stimulus(1, 32'h50, 32'h0, 4'h0, lat_got, rd_got, err_got);
        check_output("b2b_written_data", rd_got, 32'h0BADBEEF);
        check_output("b2b_readback_latency", 32'(lat_got), 32'd5);

        // Asynchronous reset in the middle of the second write beat.
        rin[2] = '{1'b1, 1'b0, 32'h90, 32'hA5A5C3C3, 4'hF};
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock); #1;
            rin[2].mem_valid = 1'b0;
        end
        check_output("arst_pre_we_n", {31'b0, we_n_a[2]}, 32'h0);
        check_output("arst_pre_addr", {24'b0, saddr[2]}, 32'h49);
        #2 reset = 1'b1;
        #1;
        check_output("arst_pins", {29'b0, we_n_a[2], ce_n_a[2], dq_oe_a[2]}, 32'b110);
        @(posedge clock); #1;
        reset = 1'b0;
        n_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            if (rout[2].mem_ready) n_ready++;
        end
        check_output("arst_no_ready", 32'(n_ready), 32'd0);
        check_output("arst_ovf_cleared", {31'b0, ovf_a[1]}, 32'h0);
        apply_stimulus(2, 32'h80, 32'h0, 4'h0, lat_got, rd_got, err_got);
        check_output("arst_next_rdata", rd_got, 32'h89ABCDEF);
        check_output("arst_next_latency", 32'(lat_got), 32'd7);

        // Randomised sweep over all beat lengths against the word-level reference.
        for (int k = 0; k < NW; k++)
            for (int i = 0; i < 128; i++) ref_mem[k][i] = $urandom;
        init_go = 1'b1;
        @(posedge clock); #1;
        init_go = 1'b0;
        for (int s = 0; s < NW; s++) begin
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(9, 0);
                d = $urandom;
                if (r == 0) begin
                    word = $urandom_range(32'h3FFF_FFFF, 256);
                    e    = 1'b1;
                end else begin
                    word = $urandom_range(127, 0);
                    e    = 1'b0;
                end
                a  = {word[29:0], 2'($urandom_range(3, 0))};
                st = (r < 5) ? 4'h0 : 4'($urandom_range(15, 1));
                exp_rd = (!e && st == 4'h0) ? ref_mem[s][word[6:0]] : 32'h0;
                apply_stimulus(s, a, d, st, lat_got, rd_got, err_got);
                check_output($sformatf("rand_w%0d_rdata", s), rd_got, exp_rd);
                check_output($sformatf("rand_w%0d_error", s), {31'b0, err_got}, {31'b0, e});
                check_output($sformatf("rand_w%0d_latency", s), 32'(lat_got), 32'(exp_latency(s, st, e)));
                if (!e && st != 4'h0)
                    for (int b = 0; b < 4; b++)
                        if (st[b]) ref_mem[s][word[6:0]][b*8 +: 8] = d[b*8 +: 8];
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
